core_inst_seq: RTL and testbench
================================

# core_inst_seq

Instruction sequencer that sits directly upstream of `core` and drives its 47-bit `inst` bus. It replaces hand-scripted stimulus for one kernel-position pass (kij). On a single `start` pulse it walks the whole pass: weight fetch into the input FIFO, weight injection into the PEs, activation streaming through L0 with execute, array drain, and OFIFO read-out into psum memory at `len_nij*kij`. Accumulation and SFU readback are out of scope.

## Interface
- `row`, 8, PE rows (input channels)
- `col`, 8, PE columns (output channels)
- `len_nij`, 36, activation vectors per pass
- `len_kij`, 9, kernel positions; legal kij range is 0..len_kij-1
- `gap`, 10, idle cycles between weight injection and activation feed
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low (reset==0 resets on the next rising clk)
- `start`  in  1  single-cycle request to begin a pass
- `kij`  in  4  kernel position, sampled with `start`
- `ofifo_valid`  in  1  from `core`; OFIFO holds at least one word
- `inst`  out  47  registered instruction word to `core.inst`
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse at pass end
- `err`  out  1  one-cycle pulse when `start` carries an illegal kij

## Operation
- `inst` field map: [46] CEN_xmem, [45] WEN_xmem, [44:34] A_xmem, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_wmem, [18] WEN_wmem, [17:7] A_wmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- IDLE word: all CEN/WEN = 1, all addresses 0, all other bits 0. This is 47'h6001_800C_0000. Every field not named for a state holds its IDLE value. `acc` is always 0.
- States and their outputs:
  - IDLE: on `start` with kij<len_kij, latch kij, clear counter, go to WLOAD. On `start` with kij>=len_kij, pulse `err` and stay in IDLE.
  - WLOAD, `col` beats, n=0..col-1: CEN_wmem=0, WEN_wmem=1, A_wmem=n, ififo_wr=1. Go to WINJ.
  - WINJ, `row+col-1` beats: ififo_rd=1, load=1. Go to GAP.
  - GAP, `gap` beats: IDLE word. Go to XFEED.
  - XFEED, `len_nij` beats, k=0..len_nij-1: CEN_xmem=0, WEN_xmem=1, A_xmem=k, l0_wr=1. For k>=1 also l0_rd=1 and execute=1. Go to DRAIN.
  - DRAIN, `row+col-1` beats: l0_rd=1, execute=1. Go to OREAD.
  - OREAD: `len_nij` transfers, m=0..len_nij-1. A transfer cycle has ofifo_valid=1 and drives ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=len_nij*kij+m. A stall cycle has ofifo_valid=0 and drives the IDLE word; m holds. After the last transfer go to DONE.
  - DONE: IDLE word, `done`=1, `busy`=1. Go to IDLE.
- A_pmem base is computed as an 11-bit product. Max with defaults is 36*8+35=323, which fits; no wrap.
- `start` while busy is ignored: no err, no restart.

## Timing
- Reset values: `inst`=IDLE word, `busy`=0, `done`=0, `err`=0, state=IDLE, counters 0.
- Reset asserted in any state forces all of the above on the next edge. A partial pass is abandoned, not resumed.
- `start` sampled high at edge T: the first WLOAD word and `busy`=1 appear after edge T+1.
- `err` appears after edge T+1 and lasts one cycle.
- `ofifo_valid` is sampled in the same cycle it gates. The decision is registered into `inst` at the next edge, so each transfer consumes exactly the OFIFO word indicated valid.
- Zero-stall pass length is col + (row+col-1) + gap + len_nij + (row+col-1) + len_nij + 1 (DONE) = 121 cycles with defaults.
- `busy` is high for exactly those cycles. It drops in the cycle after `done`.
- A new `start` is accepted in the cycle after DONE, i.e. back-to-back passes are allowed.

## Test plan
- Reset with reset=0 for 3 cycles -> `inst`=47'h6001_800C_0000; busy, done and err all 0.
- start with kij=0, ofifo_valid tied 1 -> the following must all hold:
  - 8 WLOAD beats with A_wmem 0..7;
  - 15 load/ififo_rd beats, then 10 idle beats;
  - 36 l0_wr beats with A_xmem 0..35, and execute first seen on beat 2 of XFEED;
  - 15 drain beats;
  - 36 ofifo_rd beats with A_pmem 0..35;
  - done pulse 121 cycles after start.
- start with kij=8 -> OREAD A_pmem runs 288..323.
- kij=3 with ofifo_valid toggling 1,0,0,1,... -> ofifo_rd appears only in valid cycles; A_pmem is contiguous 108..143 with no skips or repeats; done is delayed by exactly the stall count.
- start with kij=9 -> err=1 for one cycle, busy stays 0. A second start pulsed mid-pass is ignored, and the pass length is unchanged.
- reset=0 during XFEED beat 20 -> the next cycle shows the IDLE word with busy=0. A subsequent start with kij=1 completes a full 121-cycle pass.

Source files
------------

// File: rtl/core_inst_seq.sv
// Instruction sequencer for one kernel-position pass of `core`: weight fetch and injection,
// activation feed with execute, array drain, then OFIFO read-out into psum memory.
module core_inst_seq #(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned len_nij = 36,
    parameter int unsigned len_kij = 9,
    parameter int unsigned gap     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  kij,
    input  logic        ofifo_valid,
    output logic [46:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle, StWload, StWinj, StGap, StXfeed, StDrain, StOread, StDone
    } state_e;

    localparam logic [46:0] IdleWord  = 47'h6001_800C_0000;
    localparam logic [7:0]  WloadLast = 8'(col - 1);
    localparam logic [7:0]  SkewLast  = 8'(row + col - 2);
    localparam logic [7:0]  GapLast   = 8'(gap - 1);
    localparam logic [7:0]  NijLast   = 8'(len_nij - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [10:0] base_q;
    logic        err_req_q;
    logic [46:0] word;
    logic        last;

    // Word for the current state; registered into `inst` one edge later.
    always_comb begin
        word = IdleWord;
        case (state_q)
            StWload: begin
                word[19]   = 1'b0;
                word[17:7] = 11'(cnt_q);
                word[5]    = 1'b1;
            end
            StWinj: begin
                word[4] = 1'b1;
                word[0] = 1'b1;
            end
            StXfeed: begin
                word[46]    = 1'b0;
                word[44:34] = 11'(cnt_q);
                word[2]     = 1'b1;
                if (cnt_q != 8'd0) begin
                    word[3] = 1'b1;
                    word[1] = 1'b1;
                end
            end
            StDrain: begin
                word[3] = 1'b1;
                word[1] = 1'b1;
            end
            StOread: begin
                if (ofifo_valid) begin
                    word[6]     = 1'b1;
                    word[32]    = 1'b0;
                    word[31]    = 1'b0;
                    word[30:20] = base_q + 11'(cnt_q);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        last = 1'b0;
        case (state_q)
            StWload:          last = (cnt_q == WloadLast);
            StWinj, StDrain:  last = (cnt_q == SkewLast);
            StGap:            last = (cnt_q == GapLast);
            StXfeed, StOread: last = (cnt_q == NijLast);
            default:          last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            base_q    <= 11'd0;
            err_req_q <= 1'b0;
            inst      <= IdleWord;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            inst      <= word;
            busy      <= (state_q != StIdle);
            done      <= (state_q == StDone);
            err       <= err_req_q;
            err_req_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (32'(kij) < len_kij) begin
                            state_q <= StWload;
                            cnt_q   <= 8'd0;
                            base_q  <= 11'(len_nij * 32'(kij));
                        end else begin
                            err_req_q <= 1'b1;
                        end
                    end
                end
                StWload, StWinj, StGap, StXfeed, StDrain: begin
                    if (last) begin
                        cnt_q <= 8'd0;
                        case (state_q)
                            StWload: state_q <= StWinj;
                            StWinj:  state_q <= StGap;
                            StGap:   state_q <= StXfeed;
                            StXfeed: state_q <= StDrain;
                            default: state_q <= StOread;
                        endcase
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StOread: begin
                    // Stall cycles hold the transfer index so psum addresses stay contiguous.
                    if (ofifo_valid) begin
                        if (last) begin
                            state_q <= StDone;
                            cnt_q   <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: walks full passes cycle by cycle against a phase model.
module tb_core_inst_seq;

    localparam logic [46:0] IDLE = 47'h6001_800C_0000;
    localparam int PhIdle  = 0;
    localparam int PhWload = 1;
    localparam int PhWinj  = 2;
    localparam int PhGap   = 3;
    localparam int PhXfeed = 4;
    localparam int PhDrain = 5;
    localparam int PhOread = 6;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  kij;
    logic        ofifo_valid;
    logic [46:0] inst;
    logic        busy;
    logic        done;
    logic        err;

    int vectors;
    int miscompares;

    core_inst_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .kij         (kij),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [46:0] obs, input logic [46:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [46:0] exp_word(input int ph, input int n, input int k);
        logic [46:0] w;
        w = IDLE;
        case (ph)
            PhWload: begin w[19] = 1'b0; w[17:7] = 11'(n); w[5] = 1'b1; end
            PhWinj:  begin w[4] = 1'b1; w[0] = 1'b1; end
            PhXfeed: begin
                w[46] = 1'b0; w[44:34] = 11'(n); w[2] = 1'b1;
                if (n >= 1) begin w[3] = 1'b1; w[1] = 1'b1; end
            end
            PhDrain: begin w[3] = 1'b1; w[1] = 1'b1; end
            PhOread: begin w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(36 * k + n); end
            default: ;
        endcase
        return w;
    endfunction

    task automatic pulse_start(input logic [3:0] k);
        kij   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks one whole pass after the start edge; tog gives ofifo_valid = 1,0,0,1,0,0,...
    task automatic expect_pass(input int k, input bit tog, input bit mid);
        int ph_tab[5];
        int len_tab[5];
        int cyc;
        int m;
        int idx;
        int stalls;
        int guard;
        bit prev;
        ph_tab  = '{PhWload, PhWinj, PhGap, PhXfeed, PhDrain};
        len_tab = '{8, 15, 10, 36, 15};
        cyc = 0;
        ofifo_valid = 1'b1;
        for (int p = 0; p < 5; p++) begin
            for (int n = 0; n < len_tab[p]; n++) begin
                tick();
                start = 1'b0;
                cyc++;
                check($sformatf("k%0d_ph%0d_beat%0d", k, ph_tab[p], n), inst,
                      exp_word(ph_tab[p], n, k));
                check($sformatf("k%0d_flags_c%0d", k, cyc), {44'd0, busy, done, err},
                      47'b100);
                if (mid && ph_tab[p] == PhXfeed && n == 5) begin
                    kij   = 4'd9;
                    start = 1'b1;
                end
            end
        end
        ofifo_valid = 1'b1;
        m = 0; idx = 0; stalls = 0; guard = 0;
        prev = 1'b1;
        while (m < 36 && guard < 300) begin
            tick();
            cyc++;
            guard++;
            if (prev) begin
                check($sformatf("k%0d_oread_m%0d", k, m), inst, exp_word(PhOread, m, k));
                m++;
            end else begin
                check($sformatf("k%0d_stall_i%0d", k, idx), inst, IDLE);
                stalls++;
            end
            idx++;
            ofifo_valid = tog ? ((idx % 3) == 0) : 1'b1;
            prev = ofifo_valid;
        end
        if (guard >= 300) begin
            miscompares++;
            $error("FAIL k%0d_oread_timeout: observed %0d transfers expected 36", k, m);
        end
        ofifo_valid = 1'b1;
        tick();
        cyc++;
        check($sformatf("k%0d_done_word", k), inst, IDLE);
        check($sformatf("k%0d_done_flags", k), {44'd0, busy, done, err}, 47'b110);
        check($sformatf("k%0d_pass_len", k), 47'(cyc), 47'(121 + stalls));
        if (tog) check("k3_stall_count", 47'(stalls), 47'd70);
        tick();
        check($sformatf("k%0d_after_flags", k), {44'd0, busy, done, err}, 47'b000);
        check($sformatf("k%0d_after_word", k), inst, IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        start = 1'b0;
        kij = 4'd0;
        ofifo_valid = 1'b0;
        repeat (3) tick();
        check("reset_inst", inst, 47'h6001_800C_0000);
        check("reset_flags", {44'd0, busy, done, err}, 47'b000);
        reset = 1'b1;
        tick();
        check("idle_flags", {44'd0, busy, done, err}, 47'b000);

        pulse_start(4'd0);
        expect_pass(0, 1'b0, 1'b0);

        pulse_start(4'd8);
        expect_pass(8, 1'b0, 1'b1);

        pulse_start(4'd3);
        expect_pass(3, 1'b1, 1'b0);

        pulse_start(4'd9);
        check("err_next_edge", {44'd0, busy, done, err}, 47'b000);
        tick();
        check("err_pulse", {44'd0, busy, done, err}, 47'b001);
        check("err_word", inst, IDLE);
        tick();
        check("err_cleared", {44'd0, busy, done, err}, 47'b000);

        // Abandon a pass mid-feed with reset.
        pulse_start(4'd0);
        repeat (54) tick();
        check("pre_reset_xfeed20", inst, exp_word(PhXfeed, 20, 0));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset_inst", inst, IDLE);
        check("midreset_flags", {44'd0, busy, done, err}, 47'b000);
        tick();
        check("midreset_stays_idle", {44'd0, busy, done, err}, 47'b000);

        pulse_start(4'd1);
        expect_pass(1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
